// File: rtl/arith_pkg.sv
// Shared opcode and FSM state encodings for the sequential arithmetic unit.
// Pure types only; no logic and no latency of its own.
package arith_pkg;
  typedef enum logic { OP_ADD = 1'b0, OP_MUL = 1'b1 } op_e;
  typedef enum logic [1:0] { IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2 } state_e;
endpackage

// File: rtl/shift_add_core.sv
// Shift-add multiplier datapath, one multiplier bit per step, WIDTH steps per product.
// Loads on the accept edge; the owner decides when to step, so it has no backpressure of its own.
module shift_add_core
  import arith_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   prod_next
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign last = (cnt == CW'(WIDTH - 1));

  // Two's-complement multiplier MSB carries weight -2^(WIDTH-1), so that row is subtracted.
  always_comb begin
    prod_next = prod;
    if (mplier[0]) begin
      prod_next = (SIGNED && last) ? (prod - mcand) : (prod + mcand);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{SIGNED && a[WIDTH-1]}}, a};
      prod   <= '0;
      mplier <= b;
      cnt    <= '0;
    end else if (step) begin
      prod   <= prod_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seq_arith_unit.sv
// Sequential add/multiply unit with valid/ready in and out: add 2 cycles, mul WIDTH+1 cycles to out_valid.
// One operation in flight; in_ready stays low until the result is taken. SEQ_ARITH_ACC_EN adds result accumulation.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
`ifdef SEQ_ARITH_ACC_EN
  ,
  input  logic                 acc
`endif
);
  state_e             state, state_nxt;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               accept, finish, step, core_last;
  logic [2*WIDTH-1:0] sum, prod_next, value, result_new;

  assign accept = in_valid && in_ready;
  assign step   = (state == BUSY) && (op_q == OP_MUL);

  shift_add_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_core (
    .clk       (clk),
    .rstn      (rstn),
    .load      (accept),
    .step      (step),
    .a         (a),
    .b         (b),
    .last      (core_last),
    .prod_next (prod_next)
  );

  // Extending both operands to 2*WIDTH first keeps the sum exact.
  assign sum   = {{WIDTH{SIGNED && a_q[WIDTH-1]}}, a_q} + {{WIDTH{SIGNED && b_q[WIDTH-1]}}, b_q};
  assign value = (op_q == OP_MUL) ? prod_next : sum;

`ifdef SEQ_ARITH_ACC_EN
  logic acc_q;
  assign result_new = value + (acc_q ? result : '0);
`else
  assign result_new = value;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (op_q == OP_ADD || core_last) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
`ifdef SEQ_ARITH_ACC_EN
      acc_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= op_e'(op);
        a_q  <= a;
        b_q  <= b;
`ifdef SEQ_ARITH_ACC_EN
        acc_q <= acc;
`endif
      end
      if (finish) result <= result_new;
    end
  end
endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have parameter SIGNED, default 0; 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  1  0 = add, 1 = multiply; sampled on accept.
REQ-008 SHALL have ports a, b  input  WIDTH each  operands; sampled on accept.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  2*WIDTH  sum or product.

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-013 IDLE: in_ready=1; accept when in_valid&&in_ready; latch a, b, op; go BUSY.
REQ-014 BUSY, op=add: one cycle; result = a+b, extended (sign or zero per SIGNED) to 2*WIDTH, exact; go DONE.
REQ-015 BUSY, op=mul: iterative shift-add, one operand bit per cycle, exactly WIDTH cycles; exact 2*WIDTH product; go DONE.
REQ-016 Latency SHALL be accept edge to out_valid high: add 2 cycles, mul WIDTH+1 cycles.
REQ-017 DONE: out_valid=1; result stable; go IDLE on the edge where out_ready=1.
REQ-018 in_ready SHALL be 0 in BUSY and DONE; no request accepted while busy or holding a result (no bypass from DONE to BUSY).
REQ-019 result SHALL keep its last value in IDLE and BUSY until overwritten at the BUSY->DONE transition.
REQ-020 SIGNED=1 multiply SHALL treat the most-negative operand correctly (-128*-128 = 16384 at WIDTH=8).
REQ-021 Changes on a, b or op after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-022 rstn low SHALL force state IDLE, in_ready=1, out_valid=0, result=0, internal registers 0, asynchronously.
REQ-023 Reset during BUSY or DONE SHALL discard the operation; no out_valid afterwards.
REQ-024 First accept SHALL be possible on the first rising edge after rstn deasserts.

Configuration
REQ-025 Macro SEQ_ARITH_ACC_EN SHALL, when defined, add input acc (1 bit, sampled on accept): acc=1 makes the new result = previous result + computed value, modulo 2^(2*WIDTH); latency unchanged; reset clears the accumulator.
REQ-026 Without SEQ_ARITH_ACC_EN, the acc port SHALL NOT exist and every result SHALL be independent of earlier ones.

Structure
REQ-027 Package arith_pkg SHALL hold the op enum (OP_ADD=0, OP_MUL=1) and the FSM state enum (IDLE, BUSY, DONE).
REQ-028 The shift-add datapath (partial-product register, bit counter) SHALL be sub-module shift_add_core, with the FSM and handshake in seq_arith_unit.

Verification (WIDTH=8)
REQ-029 mul 15*10, out_ready=1 -> result=150, out_valid exactly 9 cycles after accept, one cycle wide.
REQ-030 add 25+30 then mul 255*255 -> 55 after 2 cycles, then 65025; in_ready low throughout each operation.
REQ-031 SIGNED=1: mul -3*5 -> 0xFFF1; add -128+-1 -> 0xFF7F.
REQ-032 out_ready held low 3 cycles in DONE, operands changed -> result held, in_ready=0, in_valid ignored, release on out_ready.
REQ-033 rstn pulsed low during cycle 4 of mul 200*3 -> immediate IDLE, result=0, no out_valid; next mul 2*3 -> 6.
REQ-034 SEQ_ARITH_ACC_EN defined: mul 10*10 acc=0, then add 5+5 acc=1 -> 100, then 110.
